// File: rtl/dsp_xor_stream_ctrl_if.sv
// Operand/result stream bundle for the DSP48 XOR front-end.
// The slave modport is the controller's view; the master modport is the producer/consumer side.
interface dsp_xor_stream_ctrl_if #(
   parameter int WIDTH = 48
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_a;
   logic [WIDTH-1:0] s_b;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_result;

   modport slave (
      input  s_valid, s_a, s_b, m_ready,
      output s_ready, m_valid, m_result
   );

   modport master (
      output s_valid, s_a, s_b, m_ready,
      input  s_ready, m_valid, m_result
   );
endinterface

// File: rtl/dsp_xor_stream_ctrl.sv
// Valid/ready wrapper around the free-running DSP48 XOR macro: it tracks in-flight ops,
// captures results into a credit-protected first-word-fall-through FIFO, and streams them out.
module dsp_xor_stream_ctrl #(
   parameter int WIDTH      = 48,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   dsp_xor_stream_ctrl_if.slave io,
   output logic [WIDTH-1:0]     xor_a,
   output logic [WIDTH-1:0]     xor_b,
   output logic                 xor_ce,
   output logic                 xor_rst,
   input  logic [WIDTH-1:0]     xor_result,
   output logic                 busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PL = (LATENCY > 0) ? LATENCY : 1;

   logic             issue;
   logic             pop;
   logic             cap;
   logic [PL-1:0]    vld_pipe;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    reserved;
   logic [CW-1:0]    reserved_nxt;
   logic             s_ready_q;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   assign issue   = io.s_valid & s_ready_q;
   assign pop     = io.m_valid & io.m_ready;

   assign xor_a   = io.s_a;
   assign xor_b   = io.s_b;
   assign xor_ce  = 1'b1;
   assign xor_rst = rst;

   // The shift register mirrors the macro's pipeline; with no macro registers the
   // result is captured in the issue cycle and nothing is ever in flight.
   generate
      if (LATENCY == 0) begin : g_nopipe
         assign vld_pipe = '0;
         assign cap      = issue;
      end else begin : g_pipe
         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_pipe <= '0;
            else     vld_pipe <= (vld_pipe << 1) | PL'(issue);
         end
         assign cap = vld_pipe[PL-1];
      end
   endgenerate

   // A credit is taken at issue and returned at pop, so capture always has room.
   always_comb begin
      reserved_nxt = reserved;
      if (issue && !pop)      reserved_nxt = reserved + 1'b1;
      else if (!issue && pop) reserved_nxt = reserved - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         reserved  <= '0;
         s_ready_q <= 1'b0;
      end else begin
         if (cap) begin
            mem[wr_ptr] <= xor_result;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (cap && !pop)      count <= count + 1'b1;
         else if (!cap && pop) count <= count - 1'b1;
         reserved  <= reserved_nxt;
         s_ready_q <= (reserved_nxt < CW'(FIFO_DEPTH));
      end
   end

   assign io.s_ready  = s_ready_q;
   assign io.m_valid  = (count != '0);
   assign io.m_result = mem[rd_ptr];
   assign busy        = (reserved != '0);

endmodule

// File: tb/tb_dsp_xor_stream_ctrl.sv
// Bench for dsp_xor_stream_ctrl: two instances (48/2/4 and 8/0/2) checked every cycle
// against a queue-based transaction model, plus directed literal expectations.
module tb_dsp_xor_stream_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   dsp_xor_stream_ctrl_if #(.WIDTH(48)) a_if ();
   dsp_xor_stream_ctrl_if #(.WIDTH(8))  b_if ();

   logic [47:0] a_xa, a_xb, a_xr;
   logic        a_ce, a_xrst, a_busy;
   logic [7:0]  b_xa, b_xb, b_xr;
   logic        b_ce, b_xrst, b_busy;

   dsp_xor_stream_ctrl #(.WIDTH(48), .LATENCY(2), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .io(a_if.slave),
      .xor_a(a_xa), .xor_b(a_xb), .xor_ce(a_ce), .xor_rst(a_xrst),
      .xor_result(a_xr), .busy(a_busy)
   );

   dsp_xor_stream_ctrl #(.WIDTH(8), .LATENCY(0), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .rst(rst), .io(b_if.slave),
      .xor_a(b_xa), .xor_b(b_xb), .xor_ce(b_ce), .xor_rst(b_xrst),
      .xor_result(b_xr), .busy(b_busy)
   );

   // Macro stand-ins: two-register XOR with CE/RST, and a combinational XOR.
   logic [47:0] a_p1, a_p2;
   always @(posedge clk or posedge a_xrst) begin
      if (a_xrst) begin
         a_p1 <= '0;
         a_p2 <= '0;
      end else if (a_ce) begin
         a_p1 <= a_xa ^ a_xb;
         a_p2 <= a_p1;
      end
   end
   assign a_xr = a_p2;
   assign b_xr = b_xa ^ b_xb;

   // Transaction model: every accepted pair is outstanding until popped and
   // becomes visible LATENCY+1 cycles after the edge that accepted it.
   typedef struct {
      logic [47:0] v;
      int          t;
   } ent_t;
   ent_t qa[$];
   ent_t qb[$];
   int   cyc = 0;
   bit   up  = 1'b0;

   function automatic bit va_exp();
      return qa.size() > 0 && qa[0].t <= cyc;
   endfunction
   function automatic bit vb_exp();
      return qb.size() > 0 && qb[0].t <= cyc;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qa.delete();
         qb.delete();
         up = 1'b0;
      end else begin
         bit va, sa, vb, sb;
         va = va_exp();
         vb = vb_exp();
         sa = up && qa.size() < 4;
         sb = up && qb.size() < 2;
         if (va && a_if.m_ready) void'(qa.pop_front());
         if (vb && b_if.m_ready) void'(qb.pop_front());
         if (a_if.s_valid && sa) qa.push_back('{v: a_if.s_a ^ a_if.s_b, t: cyc + 3});
         if (b_if.s_valid && sb) qb.push_back('{v: 48'(b_if.s_a ^ b_if.s_b), t: cyc + 1});
         up = 1'b1;
         cyc++;
      end
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("a_s_ready", 48'(a_if.s_ready), 48'(up && qa.size() < 4));
      check("a_m_valid", 48'(a_if.m_valid), 48'(va_exp()));
      check("a_busy",    48'(a_busy),       48'(qa.size() != 0));
      if (va_exp()) check("a_m_result", a_if.m_result, qa[0].v);
      if (rst)      check("a_rst_m_result", a_if.m_result, 48'h0);
      check("a_reserved", 48'(dut_a.reserved), 48'(qa.size()));
      check("a_invariant", 48'(int'(dut_a.count) + $countones(dut_a.vld_pipe)), 48'(dut_a.reserved));
      check("a_pins", {a_xa ^ a_if.s_a, a_xb ^ a_if.s_b}, 96'h0);
      check("a_ce_rst", {46'h0, a_ce, a_xrst}, {46'h0, 1'b1, rst});

      check("b_s_ready", 48'(b_if.s_ready), 48'(up && qb.size() < 2));
      check("b_m_valid", 48'(b_if.m_valid), 48'(vb_exp()));
      check("b_busy",    48'(b_busy),       48'(qb.size() != 0));
      if (vb_exp()) check("b_m_result", 48'(b_if.m_result), qb[0].v);
      if (rst)      check("b_rst_m_result", 48'(b_if.m_result), 48'h0);
      check("b_reserved", 48'(dut_b.reserved), 48'(qb.size()));
      check("b_invariant", 48'(int'(dut_b.count) + $countones(dut_b.vld_pipe)), 48'(dut_b.reserved));
      check("b_pins", 48'({b_xa ^ b_if.s_a, b_xb ^ b_if.s_b, b_ce, b_xrst}), 48'({16'h0, 1'b1, rst}));
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      a_if.s_valid = 0; a_if.s_a = '0; a_if.s_b = '0; a_if.m_ready = 0;
      b_if.s_valid = 0; b_if.s_a = '0; b_if.s_b = '0; b_if.m_ready = 0;

      // Reset held for 3 cycles
      step(3);
      check("rst_s_ready",  48'(a_if.s_ready), 48'h0);
      check("rst_m_valid",  48'(a_if.m_valid), 48'h0);
      check("rst_busy",     48'(a_busy),       48'h0);
      check("rst_m_result", a_if.m_result,     48'h0);
      rst = 0;
      #1 check("rel_s_ready_low", 48'(a_if.s_ready), 48'h0);
      step();
      check("rel_s_ready_high", 48'(a_if.s_ready), 48'h1);

      // Single op, issued at cycle 0
      a_if.s_valid = 1; a_if.s_a = 48'hFFFF0000FFFF; a_if.s_b = 48'h0F0F0F0F0F0F;
      step();
      a_if.s_valid = 0;
      step();
      check("single_c2_m_valid", 48'(a_if.m_valid), 48'h0);
      step();
      check("single_c3_m_valid", 48'(a_if.m_valid), 48'h1);
      check("single_m_result",   a_if.m_result,     48'hF0F00F0FF0F0);
      a_if.m_ready = 1;
      step();
      check("single_busy_after_pop", 48'(a_busy), 48'h0);

      // Streaming 16 back-to-back pairs
      for (int i = 0; i < 16; i++) begin
         a_if.s_valid = 1;
         a_if.s_a = 48'({$urandom(), $urandom()});
         a_if.s_b = 48'({$urandom(), $urandom()});
         check("stream_s_ready", 48'(a_if.s_ready), 48'h1);
         if (i >= 3) check("stream_m_valid", 48'(a_if.m_valid), 48'h1);
         step();
      end
      a_if.s_valid = 0;
      for (int i = 0; i < 3; i++) begin
         check("stream_tail_valid", 48'(a_if.m_valid), 48'h1);
         step();
      end
      check("stream_done", 48'(a_if.m_valid), 48'h0);

      // Backpressure: exactly 4 accepted, then credits return after the first pop
      a_if.m_ready = 0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         a_if.s_valid = 1;
         a_if.s_a = 48'({$urandom(), $urandom()});
         a_if.s_b = 48'({$urandom(), $urandom()});
         if (a_if.s_ready) acc++;
         step();
      end
      check("bp_accepted", 48'(acc), 48'd4);
      check("bp_s_ready_low", 48'(a_if.s_ready), 48'h0);
      a_if.s_valid = 0;
      a_if.m_ready = 1;
      step();
      check("bp_credit_return", 48'(a_if.s_ready), 48'h1);
      step(3);
      check("bp_drained", 48'(a_if.m_valid), 48'h0);

      // Reset between edges with three ops in flight
      for (int i = 0; i < 3; i++) begin
         a_if.s_valid = 1;
         a_if.s_a = 48'({$urandom(), $urandom()});
         a_if.s_b = 48'({$urandom(), $urandom()});
         step();
      end
      a_if.s_valid = 0;
      check("mid_pre_valid", 48'(a_if.m_valid), 48'h1);
      #2 rst = 1;
      #1;
      check("mid_m_valid_drop", 48'(a_if.m_valid), 48'h0);
      check("mid_busy_drop",    48'(a_busy),       48'h0);
      step(2);
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("mid_no_stale", 48'(a_if.m_valid), 48'h0);
      end

      // Narrow, zero-latency, depth-2 instance
      b_if.s_valid = 1; b_if.s_a = 8'hA5; b_if.s_b = 8'h3C; b_if.m_ready = 0;
      step();
      b_if.s_valid = 0;
      check("b_single_valid",  48'(b_if.m_valid),  48'h1);
      check("b_single_result", 48'(b_if.m_result), 48'h99);
      b_if.m_ready = 1;
      step();
      for (int i = 0; i < 20; i++) begin
         b_if.s_valid = 1;
         b_if.s_a = 8'($urandom());
         b_if.s_b = 8'($urandom());
         b_if.m_ready = i[0];
         step();
      end
      b_if.s_valid = 0;
      b_if.m_ready = 1;
      step(4);
      check("b_drained_valid", 48'(b_if.m_valid), 48'h0);
      check("b_drained_busy",  48'(b_busy),       48'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dsp_xor_stream_ctrl.md
# dsp_xor_stream_ctrl

Stream front-end for the DSP48-based XOR macro. Accepts operand pairs on a valid/ready slave port and drives the macro's A/B/CE/RST pins. Tracks each operation through the macro's fixed pipeline latency and lands results in a small credit-protected output FIFO. Presents results on a valid/ready master port, so the free-running DSP pipeline can sit in a back-pressured datapath without losing data.

## Interface
- WIDTH, 48, operand/result width; 1..48, must equal the macro's WIDTH.
- LATENCY, 2, macro register latency; 0..2, must equal the macro's LATENCY.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥ LATENCY+2 for full throughput, minimum 2.
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid & s_ready at a rising edge.
- s_a  in  WIDTH  operand A.
- s_b  in  WIDTH  operand B.
- m_valid  out  1  result available.
- m_ready  in  1  consumer accepts result.
- m_result  out  WIDTH  A XOR B, in issue order.
- xor_a  out  WIDTH  to macro A; equals s_a combinationally.
- xor_b  out  WIDTH  to macro B; equals s_b combinationally.
- xor_ce  out  1  to macro CE; constant 1 (pipeline free-runs).
- xor_rst  out  1  to macro RST; equals RST.
- xor_result  in  WIDTH  from macro RESULT.
- busy  out  1  high while any operation is in flight or buffered.

## Operation
- Issue: issue = s_valid & s_ready. No other qualification. Operands are passed straight to the macro in the issue cycle.
- In-flight tracker: a LATENCY-bit shift register vld_pipe, with bit 0 loaded with issue each edge.
  - Capture strobe cap = vld_pipe[LATENCY-1].
  - For LATENCY=0, cap = issue, and xor_result is captured in the same cycle.
- Capture: on cap, write xor_result into the FIFO at wr_ptr and increment wr_ptr. Capture never checks for full; the credit scheme guarantees space.
- FIFO: first-word-fall-through.
  - m_valid = (count ≠ 0).
  - m_result = mem[rd_ptr].
  - Pop on m_valid & m_ready, then increment rd_ptr.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Credit counter `reserved` (0..FIFO_DEPTH): +1 on issue, −1 on pop; both in the same cycle leaves it unchanged.
- s_ready is registered: next value = (reserved_next < FIFO_DEPTH). There is no combinational path from m_ready to s_ready.
- count: +1 on capture, −1 on pop, unchanged when both occur.
- busy = (reserved ≠ 0).
- Invariant: count + popcount(vld_pipe) = reserved ≤ FIFO_DEPTH. The bench asserts this every cycle.
- Reset mid-operation:
  - All in-flight and buffered results are discarded.
  - vld_pipe, pointers, count and reserved clear immediately.
  - The macro's pipeline is cleared via xor_rst. Stale macro output is never captured because vld_pipe is zero.

## Timing
- Reset values: s_ready=0, m_valid=0, busy=0, m_result=mem[0], with FIFO memory reset to 0 so m_result=0. xor_ce=1. xor_rst follows RST.
- s_ready rises at the first rising edge after RST deasserts.
- Issue at the edge ending cycle k → xor_result valid in cycle k+LATENCY → captured at the end of that cycle → m_valid high in cycle k+LATENCY+1.
- Slave-to-master latency is LATENCY+1 cycles.
- Throughput is 1 result/cycle with m_ready held high, provided FIFO_DEPTH ≥ LATENCY+2.
- Credit return: a pop at the edge ending cycle j lets s_ready rise in cycle j+1.
- Full: reserved=FIFO_DEPTH forces s_ready=0. m_valid and m_result stay stable while m_ready=0.
- Simultaneous capture and pop at count=FIFO_DEPTH is legal; count is unchanged.

## Test plan
- Reset: assert RST for 3 cycles → s_ready=0, m_valid=0, busy=0, m_result=0. After release, s_ready=1 one edge later.
- Single op (WIDTH=48, LATENCY=2): s_a=0xFFFF0000FFFF, s_b=0x0F0F0F0F0F0F issued at cycle 0 → m_valid=1 in cycle 3 with m_result=0xF0F00F0FF0F0. busy=0 after the pop.
- Streaming: 16 random pairs back-to-back with m_ready=1 → s_ready stays high, 16 results arrive consecutively, in order, each equal to a^b.
- Backpressure: m_ready=0 with s_valid held → exactly 4 issues accepted, then s_ready=0 and m_result stable. Raise m_ready → 4 results drain in order and s_ready returns one cycle after the first pop.
- Reset mid-flight: issue 3 pairs, assert RST asynchronously between edges → m_valid and busy drop immediately. After release, no stale result ever appears.
- Parameterization (WIDTH=8, LATENCY=0, FIFO_DEPTH=2): s_a=0xA5, s_b=0x3C → m_result=0x99 one cycle after issue. Run with alternating m_ready; the invariant must hold throughout.
